v3_pulse_gen: RTL

Synthetic detector-pulse source for the v3 shaping-filter chain. It produces an ADC-format sample stream at the filter's input port, sample for sample. Each pulse is a linear rise of programmable amplitude followed by an exponential decay, riding on a programmable baseline. Pulses start from a free-running period counter or an external trigger, which gives the filter bench and on-board self-test a known, repeatable signal.

---
 rtl/package_settings.sv | 10 +
 rtl/v3_pulse_gen_pkg.sv | 19 +
 rtl/v3_pulse_gen_if.sv | 29 ++
 rtl/v3_pulse_gen_period_counter.sv | 33 +++
 rtl/v3_pulse_gen.sv | 125 ++++++++++++
 5 files changed

// File: rtl/package_settings.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | package_settings                                                     |
// | Global sample-format settings shared by the v3 filter chain.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package package_settings;
  localparam int SIZE_ADC_DATA = 12;
endpackage
`default_nettype wire

// File: rtl/v3_pulse_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | v3_pulse_gen_parameters                                              |
// | Defaults and FSM state encoding for the synthetic pulse generator.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package v3_pulse_gen_parameters;
  localparam int c_PERIOD_DEFAULT      = 256;
  localparam int c_RISE_SHIFT_DEFAULT  = 2;
  localparam int c_DECAY_SHIFT_DEFAULT = 4;
  localparam int c_FRAC_DEFAULT        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RISE  = 2'd1,
    ST_DECAY = 2'd2
  } pg_state_t;
endpackage
`default_nettype wire

// File: rtl/v3_pulse_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | v3_pulse_gen_if                                                      |
// | Control and sample-stream signals of the synthetic pulse source.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface v3_pulse_gen_if #(
  parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA
);
  logic                     enable;
  logic                     trig;
  logic [SIZE_ADC_DATA-1:0] amplitude;
  logic [SIZE_ADC_DATA-1:0] baseline;
  logic [SIZE_ADC_DATA-1:0] output_data;
  logic                     pulse_start;
  logic                     busy;
  logic [15:0]              pulse_count;

  modport master (
    output enable, trig, amplitude, baseline,
    input  output_data, pulse_start, busy, pulse_count
  );

  modport slave (
    input  enable, trig, amplitude, baseline,
    output output_data, pulse_start, busy, pulse_count
  );
endinterface
`default_nettype wire

// File: rtl/v3_pulse_gen_period_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | v3_period_counter                                                    |
// | Free-running 0..PERIOD-1 counter with a one-cycle wrap strobe.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module v3_period_counter #(
  parameter int PERIOD = 256
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_enable,
  output logic      o_wrap
);
  localparam int              c_CW   = $clog2(PERIOD);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(PERIOD - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_enable || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobe is combinational so the first trigger lands exactly PERIOD edges after reset
  assign o_wrap = i_enable && (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/v3_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | v3_pulse_gen                                                         |
// | Linear-rise / exponential-decay pulse source on a live baseline.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module v3_pulse_gen
  import package_settings::*;
  import v3_pulse_gen_parameters::*;
#(
  parameter int PERIOD      = c_PERIOD_DEFAULT,
  parameter int RISE_SHIFT  = c_RISE_SHIFT_DEFAULT,
  parameter int DECAY_SHIFT = c_DECAY_SHIFT_DEFAULT,
  parameter int FRAC        = c_FRAC_DEFAULT
) (
  input wire logic        clk,
  input wire logic        reset,
  v3_pulse_gen_if.slave   bus
);
  localparam int               c_W         = SIZE_ADC_DATA;
  localparam int               c_AW        = SIZE_ADC_DATA + FRAC;
  localparam int               c_RCW       = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam logic [c_RCW-1:0] c_RISE_LAST = c_RCW'((1 << RISE_SHIFT) - 1);

  pg_state_t        r_state, w_state_next;
  logic [c_AW-1:0]  r_acc, w_acc_next;
  logic [c_W-1:0]   r_amp, r_out;
  logic [c_RCW-1:0] r_rise_cnt;
  logic             r_pulse_start, r_busy;
  logic [15:0]      r_count;
  logic             w_auto, w_go, w_start;

  v3_period_counter #(.PERIOD(PERIOD)) u_period (
    .clk      (clk),
    .reset    (reset),
    .i_enable (bus.enable),
    .o_wrap   (w_auto)
  );

  assign w_go = bus.trig | w_auto;

  logic [c_AW-1:0] w_step, w_rise_acc, w_decay_acc;
  logic [c_AW:0]   w_rise_sum;
  logic [c_W:0]    w_out_sum;
  logic [c_W-1:0]  w_out_sat;

  assign w_step      = c_AW'(r_amp) << (FRAC - RISE_SHIFT);
  assign w_rise_sum  = {1'b0, r_acc} + {1'b0, w_step};
  assign w_rise_acc  = w_rise_sum[c_AW] ? {c_AW{1'b1}} : w_rise_sum[c_AW-1:0];
  assign w_decay_acc = r_acc - (r_acc >> DECAY_SHIFT);
  assign w_out_sum   = {1'b0, bus.baseline} + {1'b0, r_acc[c_AW-1:FRAC]};
  assign w_out_sat   = w_out_sum[c_W] ? {c_W{1'b1}} : w_out_sum[c_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // A trigger in DECAY restarts the rise from the current level (pile-up)
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_start      = 1'b1;
          w_state_next = ST_RISE;
        end
      end
      ST_RISE: begin
        if (r_rise_cnt == c_RISE_LAST) w_state_next = ST_DECAY;
      end
      ST_DECAY: begin
        if (w_go) begin
          w_start      = 1'b1;
          w_state_next = ST_RISE;
        end else if (w_decay_acc[c_AW-1:FRAC] == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_acc_next = r_acc;
    case (r_state)
      ST_RISE:  w_acc_next = w_rise_acc;
      ST_DECAY: begin
        if (!w_go) w_acc_next = (w_decay_acc[c_AW-1:FRAC] == '0) ? '0 : w_decay_acc;
      end
      default:  w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc         <= '0;
      r_amp         <= '0;
      r_rise_cnt    <= '0;
      r_pulse_start <= 1'b0;
      r_busy        <= 1'b0;
      r_count       <= '0;
      r_out         <= '0;
    end else begin
      r_acc         <= w_acc_next;
      r_pulse_start <= w_start;
      r_busy        <= (r_state != ST_IDLE);
      r_out         <= w_out_sat;
      if (w_start) begin
        r_amp      <= bus.amplitude;
        r_rise_cnt <= '0;
        r_count    <= r_count + 16'd1;
      end else if (r_state == ST_RISE) begin
        r_rise_cnt <= r_rise_cnt + 1'b1;
      end
    end
  end

  assign bus.output_data = r_out;
  assign bus.pulse_start = r_pulse_start;
  assign bus.busy        = r_busy;
  assign bus.pulse_count = r_count;
endmodule
`default_nettype wire
